// File: rtl/rx_1553_decoder_if.sv
// Single-entry word stream from the 1553 receive decoder to its consumer.
// tvalid/tready handshake; tdata/tuser hold steady while tvalid is high.
interface rx_1553_decoder_if;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/rx_1553_decoder.sv
// 1553 receive front end: sync detect + Manchester II decode of 16 data bits and odd parity.
// Word appears 1 aclk after the parity h2 sample; a word finishing while the previous one is unaccepted is dropped with rx_abort.
module rx_1553_decoder #(
  parameter int CLOCK_SPEED = 100000000,
  parameter int SAMPLE_RATE = 8000000,
  parameter bit INVERT_DATA = 1'b0,
  parameter int SYNC_TOL    = 1
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [1:0]        i_diff,
  rx_1553_decoder_if.master m_axis,
  output logic              rx_busy,
  output logic              rx_abort
);
  localparam int DIV      = CLOCK_SPEED / SAMPLE_RATE;
  localparam int SPB      = SAMPLE_RATE / 1000000;
  localparam int H        = SPB / 2;
  localparam int SYNC_LEN = 3 * H;
  localparam int RUN_MAX  = 4 * SPB;
  localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW       = $clog2(RUN_MAX + 1);
  localparam int EW       = $clog2(SYNC_LEN + 1);
  localparam int BW       = $clog2(SPB);

  typedef enum logic [1:0] {IDLE, SYNC2, DATA, DONE} state_t;

  logic [PW-1:0] pre_q;
  logic          tick;
  logic [1:0]    sync1_q, sync2_q;
  logic          line_vld, line_lvl;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          prev_q, prev_d;
  logic          a_q, a_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [4:0]    bidx_q, bidx_d;
  logic          h1_q, h1_d, h1v_q, h1v_d;
  logic [15:0]   shift_q, shift_d;
  logic          par_q, par_d;
  logic [15:0]   tdata_q, tdata_d;
  logic [1:0]    tuser_q, tuser_d;
  logic          tvalid_q, tvalid_d;
  logic          abort_q, abort_d;
  logic          in_win;

  assign tick     = (pre_q == PW'(DIV - 1));
  assign line_vld = sync2_q[1] ^ sync2_q[0];
  assign line_lvl = sync2_q[1] ^ INVERT_DATA;
  assign in_win   = (run_q >= RW'(SYNC_LEN - SYNC_TOL)) && (run_q <= RW'(SYNC_LEN + SYNC_TOL));

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      pre_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      run_q    <= '0;
      prev_q   <= 1'b0;
      a_q      <= 1'b0;
      edge_q   <= '0;
      bcnt_q   <= '0;
      bidx_q   <= '0;
      h1_q     <= 1'b0;
      h1v_q    <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      pre_q    <= tick ? '0 : pre_q + 1'b1;
      sync1_q  <= i_diff;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      a_q      <= a_d;
      edge_q   <= edge_d;
      bcnt_q   <= bcnt_d;
      bidx_q   <= bidx_d;
      h1_q     <= h1_d;
      h1v_q    <= h1v_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    prev_d   = prev_q;
    a_d      = a_q;
    edge_d   = edge_q;
    bcnt_d   = bcnt_q;
    bidx_d   = bidx_q;
    h1_d     = h1_q;
    h1v_d    = h1v_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    abort_d  = 1'b0;

    if (tvalid_q && m_axis.m_axis_tready) tvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (!line_vld) begin
            run_d = '0;
          end else if (run_q == '0 || line_lvl != prev_q) begin
            prev_d = line_lvl;
            run_d  = RW'(1);
            // The run that just ended is the first sync half; its level is the sync type.
            if (run_q != '0 && line_lvl != prev_q && in_win) begin
              a_d     = prev_q;
              edge_d  = '0;
              run_d   = '0;
              state_d = SYNC2;
            end
          end else if (run_q != RW'(RUN_MAX)) begin
            run_d = run_q + 1'b1;
          end
        end
      end

      SYNC2: begin
        if (tick) begin
          edge_d = edge_q + 1'b1;
          if ((edge_d == EW'(H + 2) || edge_d == EW'(SYNC_LEN - 2)) &&
              (!line_vld || line_lvl == a_q)) begin
            state_d = IDLE;
          end else if (edge_d == EW'(SYNC_LEN - 1)) begin
            bcnt_d  = '0;
            bidx_d  = '0;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (tick) begin
          bcnt_d = (bcnt_q == BW'(SPB - 1)) ? '0 : bcnt_q + 1'b1;
          if (bcnt_q == BW'(SPB - 1)) bidx_d = bidx_q + 1'b1;
          if (bcnt_q == BW'(H / 2)) begin
            h1_d  = line_lvl;
            h1v_d = line_vld;
          end
          if (bcnt_q == BW'(H + H / 2)) begin
            if (!h1v_q || !line_vld || h1_q == line_lvl) begin
              abort_d = 1'b1;
              run_d   = '0;
              state_d = IDLE;
            end else if (bidx_q == 5'd16) begin
              par_d   = h1_q;
              state_d = DONE;
            end else begin
              shift_d = {shift_q[14:0], h1_q};
            end
          end
        end
      end

      DONE: begin
        run_d   = '0;
        state_d = IDLE;
        if (!tvalid_q || m_axis.m_axis_tready) begin
          tdata_d  = shift_q;
          tuser_d  = {~^{shift_q, par_q}, a_q};
          tvalid_d = 1'b1;
        end else begin
          abort_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign m_axis.m_axis_tdata  = tdata_q;
  assign m_axis.m_axis_tuser  = tuser_q;
  assign m_axis.m_axis_tvalid = tvalid_q;
  assign rx_busy              = (state_q != IDLE);
  assign rx_abort             = abort_q;
endmodule

// File: tb/tb_rx_1553_decoder.sv
// Directed bench for rx_1553_decoder: word-level event model checked every cycle, plus literal spot checks.
module tb_rx_1553_decoder;
  localparam int DIV = 4;
  localparam int SPB = 8;
  localparam int K_BUSY = 0;
  localparam int K_WORD = 1;
  localparam int K_BAD  = 2;

  typedef struct {
    int          at;
    int          kind;
    logic [15:0] d;
    logic [1:0]  u;
  } ev_t;

  logic       aclk  = 1'b0;
  logic       arstn = 1'b0;
  logic [1:0] i_diff = 2'b00;
  logic       rx_busy, rx_abort;

  rx_1553_decoder_if axis();

  rx_1553_decoder #(
    .CLOCK_SPEED(32000000),
    .SAMPLE_RATE(8000000),
    .INVERT_DATA(1'b0),
    .SYNC_TOL(1)
  ) dut (
    .aclk(aclk),
    .arstn(arstn),
    .i_diff(i_diff),
    .m_axis(axis.master),
    .rx_busy(rx_busy),
    .rx_abort(rx_abort)
  );

  always #5 aclk = ~aclk;

  ev_t         evq[$];
  int          cyc = 0;
  logic        exp_vld = 0, exp_busy = 0, exp_abort = 0;
  logic [15:0] exp_d = 0;
  logic [1:0]  exp_u = 0;
  int          errors = 0, checks = 0;
  int          abort_seen = 0, busy_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: apply handshake and scheduled word events at each clock edge.
  initial forever begin
    ev_t ev;
    @(posedge aclk);
    if (arstn) begin
      cyc++;
      exp_abort = 1'b0;
      if (exp_vld && axis.m_axis_tready) exp_vld = 1'b0;
      while (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          K_BUSY: exp_busy = 1'b1;
          K_WORD: begin
            exp_busy = 1'b0;
            if (!exp_vld) begin
              exp_vld = 1'b1;
              exp_d   = ev.d;
              exp_u   = ev.u;
            end else begin
              exp_abort = 1'b1;
            end
          end
          default: begin
            exp_busy  = 1'b0;
            exp_abort = 1'b1;
          end
        endcase
      end
    end
  end

  initial forever begin
    @(negedge aclk);
    chk("vld_busy_abort", {29'd0, axis.m_axis_tvalid, rx_busy, rx_abort}, {29'd0, exp_vld, exp_busy, exp_abort});
    if (exp_vld)
      chk("word", {14'd0, axis.m_axis_tdata, axis.m_axis_tuser}, {14'd0, exp_d, exp_u});
    if (rx_abort) abort_seen++;
    if (rx_busy) busy_seen++;
  end

  // One line sample per prescaler period; returns the edge at which the decoder samples it.
  task automatic drive(input logic [1:0] v, output int seen);
    do @(negedge aclk); while (cyc % DIV != DIV - 2);
    i_diff = v;
    seen = cyc + DIV + 2;
  endtask

  task automatic idle(input int n);
    int s;
    for (int i = 0; i < n; i++) drive(2'b00, s);
  endtask

  task automatic send_word(input logic cmd, input logic [15:0] d, input logic par,
                           input int bad_bit, input int nbits);
    int   seen;
    logic lv, bitv;
    for (int i = 0; i < 24; i++) begin
      lv = (i < 12) ? cmd : ~cmd;
      drive(lv ? 2'b10 : 2'b01, seen);
      if (i == 12) evq.push_back('{seen, K_BUSY, 16'h0, 2'b00});
    end
    for (int b = 0; b < nbits; b++) begin
      bitv = (b < 16) ? d[15 - b] : par;
      for (int k = 0; k < SPB; k++) begin
        lv = (b == bad_bit) ? 1'b1 : ((k < SPB / 2) ? bitv : ~bitv);
        drive(lv ? 2'b10 : 2'b01, seen);
        if (k == 6) begin
          if (b == bad_bit)
            evq.push_back('{seen, K_BAD, 16'h0, 2'b00});
          else if (b == 16)
            evq.push_back('{seen + 1, K_WORD, d,
                            {(($countones(d) + int'(par)) % 2 == 0), cmd}});
        end
      end
    end
  endtask

  task automatic accept();
    @(negedge aclk);
    axis.m_axis_tready = 1'b1;
    @(negedge aclk);
    axis.m_axis_tready = 1'b0;
  endtask

  initial begin
    int s;
    axis.m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_tvalid", axis.m_axis_tvalid, 0);
    chk("reset_tdata", axis.m_axis_tdata, 0);
    chk("reset_tuser", axis.m_axis_tuser, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_abort", rx_abort, 0);
    #2 arstn = 1'b1;
    idle(4);

    send_word(1'b1, 16'hA5C3, 1'b1, -1, 17);
    idle(3);
    chk("cmd_word_data", axis.m_axis_tdata, 16'hA5C3);
    chk("cmd_word_user", axis.m_axis_tuser, 2'b01);
    chk("cmd_word_vld", axis.m_axis_tvalid, 1);
    accept();

    send_word(1'b0, 16'h0000, 1'b0, -1, 17);
    idle(3);
    chk("data_word_data", axis.m_axis_tdata, 16'h0000);
    chk("data_word_user", axis.m_axis_tuser, 2'b10);
    accept();
    idle(2);
    chk("accepted_vld", axis.m_axis_tvalid, 0);

    abort_seen = 0;
    send_word(1'b1, 16'hFFFF, 1'b1, 5, 6);
    idle(4);
    chk("bad_bit_aborts", abort_seen, 1);
    chk("bad_bit_vld", axis.m_axis_tvalid, 0);
    chk("bad_bit_busy", rx_busy, 0);

    abort_seen = 0;
    send_word(1'b1, 16'h1234, 1'b0, -1, 17);
    send_word(1'b1, 16'h5678, 1'b1, -1, 17);
    idle(3);
    chk("overflow_aborts", abort_seen, 1);
    chk("overflow_held_data", axis.m_axis_tdata, 16'h1234);
    chk("overflow_held_user", axis.m_axis_tuser, 2'b01);

    abort_seen = 0;
    busy_seen  = 0;
    for (int i = 0; i < 9; i++) drive(2'b10, s);
    for (int i = 0; i < 12; i++) drive(2'b01, s);
    idle(4);
    chk("short_sync_busy", busy_seen, 0);
    chk("short_sync_aborts", abort_seen, 0);

    send_word(1'b1, 16'h0F0F, 1'b1, -1, 9);
    @(negedge aclk);
    #2;
    arstn = 1'b0;
    evq.delete();
    exp_vld = 0; exp_busy = 0; exp_abort = 0; exp_d = 0; exp_u = 0;
    cyc = 0;
    i_diff = 2'b00;
    #1;
    chk("midword_reset_vld", axis.m_axis_tvalid, 0);
    chk("midword_reset_busy", rx_busy, 0);
    repeat (3) @(negedge aclk);
    #2 arstn = 1'b1;
    idle(4);
    send_word(1'b1, 16'hFFFF, 1'b1, -1, 17);
    idle(3);
    chk("post_reset_data", axis.m_axis_tdata, 16'hFFFF);
    chk("post_reset_user", axis.m_axis_tuser, 2'b01);
    chk("post_reset_vld", axis.m_axis_tvalid, 1);
    accept();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rx_1553_decoder.md
Name: rx_1553_decoder

Overview:
- Receive front end for the 1553 core. It turns the raw differential bus pair into checked 16-bit words.
- Synchronises and samples i_diff, detects the 3-bit-time sync, decodes 16 Manchester II data bits plus an odd-parity bit.
- Presents each word on a single-entry AXI-Stream style output. up_1553 consumes that output and stores it in its receive register/FIFO.
- It sits between the transceiver pins and the uP register core.

Parameters:
- CLOCK_SPEED, 100000000, aclk frequency in Hz.
- SAMPLE_RATE, 8000000, bus sample rate in Hz. Must be an integer multiple of 2000000 and divide CLOCK_SPEED evenly. SPB = SAMPLE_RATE/1000000 samples per bit (default 8); H = SPB/2.
- INVERT_DATA, 0, when 1 the decoded line level is inverted before decoding.
- SYNC_TOL, 1, allowed +/- sample error on the first sync half length.

Ports:
- aclk  in  1  clock.
- arstn  in  1  reset: asynchronous, active-low.
- i_diff  in  2  bus pair from transceiver. Bit1 = positive leg, bit0 = negative leg.
- m_axis_tdata  out  16  decoded data word, MSB first on the bus.
- m_axis_tuser  out  2  [0] sync type (1 = command/status, 0 = data); [1] parity error.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  consumer accepts.
- rx_busy  out  1  high from sync accept until the word completes or aborts.
- rx_abort  out  1  one-cycle pulse: Manchester error, invalid line state, or overflow.

Behaviour:
- Reset: all outputs 0. FSM is IDLE, counters are 0, sync flops are 0.
- Input path:
  - i_diff passes through a 2-flop synchroniser.
  - valid = (d[1] != d[0]); level = d[1] XOR INVERT_DATA.
- Sampling:
  - A prescaler counts 0..CLOCK_SPEED/SAMPLE_RATE-1 and asserts tick on the terminal count.
  - All FSM sampling happens only on tick.
- IDLE:
  - Tracks run_len (saturating at 4*SPB) of the current valid level. Invalid resets run_len to 0.
  - On a level change where the previous run_len is within 1.5*SPB +/- SYNC_TOL: store A = previous level, set edge_cnt = 0, go to SYNC2.
  - Any other change sets run_len = 1.
- SYNC2:
  - edge_cnt increments each tick.
  - Line must be valid and equal to !A at edge_cnt = H+2 and at edge_cnt = 1.5*SPB-2. Otherwise go to IDLE with no abort pulse (false sync).
  - At edge_cnt = 1.5*SPB-1: set bit_idx = 0 and go to DATA.
  - rx_busy is set on entry to SYNC2 and held until return to IDLE.
- DATA (17 bits: 16 data + parity):
  - Each bit is SPB ticks long. h1 is sampled at tick H/2, h2 at tick H + H/2 within the bit.
  - If either sample is invalid, or h1 == h2: pulse rx_abort, go to IDLE, discard the word.
  - Decoded bit = h1 (1 = high then low).
  - Bits 0..15 shift into a data register MSB first. Bit 16 is parity.
- Completion (cycle after the parity h2 tick):
  - par_err = ~^{data, parity}, i.e. the odd total-ones check fails.
  - sync type = A.
  - If m_axis_tvalid == 0: load tdata/tuser and set tvalid. Latency is 1 aclk after the parity h2 tick.
  - If m_axis_tvalid == 1 (previous word unaccepted): drop the new word, pulse rx_abort, keep the held word unchanged.
  - FSM returns to IDLE with run_len = 0. Back-to-back words with no gap must decode: the next sync is found from its first half run.
- Output handshake:
  - tvalid clears on the cycle tvalid & tready.
  - tdata/tuser are stable while tvalid is high.
  - A completion on the same cycle as acceptance loads the new word (tvalid stays 1, no abort).
- Reset mid-word: arstn low forces IDLE and clears tvalid and any held word immediately.

Test Plan:
- Command sync (high 12 samples, low 12), data 0xA5C3, parity 0 (8 ones, so odd parity bit = 1; send 1) -> tdata = 0xA5C3, tuser = 2'b01, tvalid 1 aclk after the parity h2 tick.
- Data sync (low then high), data 0x0000, parity bit 0 -> tdata = 0x0000, tuser = 2'b10 (parity error).
- Word with bit 5 halves both high -> rx_abort single pulse, tvalid stays 0, rx_busy falls.
- tready held 0, two valid words back-to-back (0x1234 then 0x5678) -> tdata remains 0x1234, one rx_abort pulse at the second completion.
- First sync half of 9 samples, then 12-sample opposite level -> no sync accepted, rx_busy never asserts, no rx_abort.
- arstn asserted at data bit 8, released, then a valid command word 0xFFFF with parity bit 1 -> first output is 0xFFFF, tuser = 2'b01.
